// File: rtl/eda_pkg.sv
// Shared definitions for the regional-maximum engine: neighbour ordering,
// pixel address layout, pixel-stack FSM states and the drain priority encoder.
package eda_pkg;

  localparam int NB_NEIGHBOURS = 8;

  // Neighbour indices, matching the iterated-RAM concatenation order.
  localparam int UPLEFT    = 7;
  localparam int UP        = 6;
  localparam int UPRIGHT   = 5;
  localparam int LEFT      = 4;
  localparam int RIGHT     = 3;
  localparam int DOWNLEFT  = 2;
  localparam int DOWN      = 1;
  localparam int DOWNRIGHT = 0;

  typedef struct packed {
    logic [3:0] i;
    logic [3:0] j;
  } pixel_addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } stack_state_e;

  function automatic logic [2:0] lowest_set(input logic [NB_NEIGHBOURS-1:0] m);
    lowest_set = '0;
    for (int i = UPLEFT; i >= DOWNRIGHT; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/eda_stack_mem.sv
// Single-write, asynchronous-read storage for the pixel stack.
// Contents reset to zero so the read port is never X after reset.
module eda_stack_mem #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/eda_pixel_stack.sv
// Flood-fill LIFO: serialises masked neighbour batches, pops one center pixel per handshake.
// Optional high-water mark output enabled by EDA_PIXEL_STACK_HWM_EN.
module eda_pixel_stack
  import eda_pkg::*;
#(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int ADDR_WIDTH = $clog2(M*N),
  parameter int DEPTH      = M*N,
  parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                clear,
  input  logic                                push_valid,
  output logic                                push_ready,
  input  logic [NB_NEIGHBOURS-1:0]            push_mask,
  input  logic [NB_NEIGHBOURS*ADDR_WIDTH-1:0] push_addrs,
  output logic                                pop_valid,
  input  logic                                pop_ready,
  output logic [ADDR_WIDTH-1:0]               pop_addr,
  output logic [CNT_WIDTH-1:0]                count,
`ifdef EDA_PIXEL_STACK_HWM_EN
  output logic [CNT_WIDTH-1:0]                max_count,
`endif
  output logic                                empty,
  output logic                                full,
  output logic                                overflow
);

  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  stack_state_e                        state_q, state_d;
  logic [NB_NEIGHBOURS-1:0]            pend_q, pend_d;
  logic [NB_NEIGHBOURS*ADDR_WIDTH-1:0] addrs_q, addrs_d;
  logic [CNT_WIDTH-1:0]                sp_q, sp_d, sp_m1;
  logic                                ovf_q, ovf_d;
  logic [2:0]                          low_idx;
  logic                                we;
  logic [ADDR_WIDTH-1:0]               wdata;
  logic [IDX_WIDTH-1:0]                raddr;
  logic                                push_fire, pop_fire;

  assign empty      = (sp_q == '0);
  assign full       = (sp_q == CNT_WIDTH'(DEPTH));
  assign count      = sp_q;
  assign overflow   = ovf_q;
  assign push_ready = (state_q == IDLE);
  assign pop_valid  = (state_q == IDLE) && !empty;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;
  assign low_idx    = lowest_set(pend_q);
  assign sp_m1      = sp_q - CNT_WIDTH'(1);
  assign raddr      = empty ? '0 : sp_m1[IDX_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addrs_d = addrs_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    wdata   = addrs_q[low_idx*ADDR_WIDTH +: ADDR_WIDTH];
    case (state_q)
      IDLE: begin
        if (pop_fire) sp_d = sp_m1;
        if (push_fire) begin
          pend_d  = push_mask;
          addrs_d = push_addrs;
          if (push_mask != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        pend_d[low_idx] = 1'b0;
        // A full stack drops the entry but the bit is still retired.
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + CNT_WIDTH'(1);
        end
        if (pend_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      pend_d  = '0;
      sp_d    = '0;
      ovf_d   = 1'b0;
      we      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      addrs_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addrs_q <= addrs_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
    end
  end

  eda_stack_mem #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(ADDR_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_mem (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .waddr  (sp_q[IDX_WIDTH-1:0]),
    .wdata  (wdata),
    .raddr  (raddr),
    .rdata  (pop_addr)
  );

`ifdef EDA_PIXEL_STACK_HWM_EN
  logic [CNT_WIDTH-1:0] max_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_count_q <= '0;
    end else if (clear) begin
      max_count_q <= '0;
    end else if (sp_q > max_count_q) begin
      max_count_q <= sp_q;
    end
  end

  assign max_count = max_count_q;
`endif

endmodule
